// File: rtl/axis_move_scheduler_if.sv
// -----------------------------------------------------------------------------
// axis_move_scheduler_if
// Bundles the handshake and drive signals of the axis move scheduler.
//   master : axis controllers / manual logic side (drives requests, sma, abort)
//   slave  : scheduler side (drives acks, drive codes, busy, active_axis, done)
// Signals:
//   sma, abort                               mode select and synchronous stop
//   req_/dir_/steps_/ack_theta, ..._phi      per-axis move request handshake
//   s_out_{theta,phi}_{pos,neg}[1:0]         two-phase drive codes
//   busy, active_axis, done                  scheduler status
// -----------------------------------------------------------------------------
interface axis_move_scheduler_if #(
    parameter int SW = 8
);
    logic          sma;
    logic          abort;
    logic          req_theta;
    logic          dir_theta;
    logic [SW-1:0] steps_theta;
    logic          ack_theta;
    logic          req_phi;
    logic          dir_phi;
    logic [SW-1:0] steps_phi;
    logic          ack_phi;
    logic [1:0]    s_out_theta_pos;
    logic [1:0]    s_out_theta_neg;
    logic [1:0]    s_out_phi_pos;
    logic [1:0]    s_out_phi_neg;
    logic          busy;
    logic          active_axis;
    logic          done;

    modport master (
        output sma, abort,
        output req_theta, dir_theta, steps_theta,
        output req_phi, dir_phi, steps_phi,
        input  ack_theta, ack_phi,
        input  s_out_theta_pos, s_out_theta_neg, s_out_phi_pos, s_out_phi_neg,
        input  busy, active_axis, done
    );

    modport slave (
        input  sma, abort,
        input  req_theta, dir_theta, steps_theta,
        input  req_phi, dir_phi, steps_phi,
        output ack_theta, ack_phi,
        output s_out_theta_pos, s_out_theta_neg, s_out_phi_pos, s_out_phi_neg,
        output busy, active_axis, done
    );
endinterface

// File: rtl/axis_move_scheduler.sv
// -----------------------------------------------------------------------------
// axis_move_scheduler
// Shares one motor power stage between the theta and phi tracker axes.
// Arbitrates move requests (fixed theta priority when sma=1, round-robin
// otherwise), inserts DEAD_T cycles of all-off before each move, then drives
// STEP_DIV cycles of phase A (01) and STEP_DIV cycles of phase B (10) per step
// on the single output chosen by the latched axis and direction.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   axis_move_scheduler_if.slave (requests in; acks, drive codes,
//         busy, active_axis, done out -- all registered)
// Optional feature macro: AXIS_SCHED_DEADSKIP_EN
//   When defined, a move with the same axis and direction as the previous
//   completed, non-aborted move skips the dead-time (IDLE goes to RUN_A).
// -----------------------------------------------------------------------------
module axis_move_scheduler #(
    parameter int SW       = 8,
    parameter int STEP_DIV = 16,
    parameter int DEAD_T   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_move_scheduler_if.slave  bus
);

    localparam int CNT_MAX = (DEAD_T > STEP_DIV) ? DEAD_T : STEP_DIV;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_T - 1);
    localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [SW-1:0] REM_ZERO  = SW'(0);
    localparam logic [SW-1:0] REM_ONE   = SW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAD  = 3'd1,
        ST_RUN_A = 3'd2,
        ST_RUN_B = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Drive code produced by a state; only the run states energise a phase.
    function automatic logic [1:0] phase_code(input state_t st);
        logic [1:0] code;
        case (st)
            ST_RUN_A: code = 2'b01;
            ST_RUN_B: code = 2'b10;
            default:  code = 2'b00;
        endcase
        return code;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] rem_q, rem_d;
    logic          axis_q, axis_d;
    logic          dir_q, dir_d;
    logic          ack_theta_q, ack_theta_d;
    logic          ack_phi_q, ack_phi_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [1:0]    theta_pos_q, theta_pos_d;
    logic [1:0]    theta_neg_q, theta_neg_d;
    logic [1:0]    phi_pos_q, phi_pos_d;
    logic [1:0]    phi_neg_q, phi_neg_d;

    logic          req_any_s;
    logic          grant_phi_s;
    logic          grant_dir_s;
    logic [SW-1:0] grant_steps_s;
    logic          skip_dead_s;
    logic [1:0]    code_s;

`ifdef AXIS_SCHED_DEADSKIP_EN
    // History of the last move that ran to completion without abort.
    logic          hist_valid_q, hist_valid_d;
    logic          hist_axis_q, hist_axis_d;
    logic          hist_dir_q, hist_dir_d;
`endif

    // Arbitration: pick the winning axis and its request fields.
    always_comb begin
        req_any_s = bus.req_theta | bus.req_phi;
        if (bus.req_theta && bus.req_phi) begin
            if (bus.sma) begin
                grant_phi_s = 1'b0;
            end else begin
                // Round-robin: the axis that was not granted last time wins.
                grant_phi_s = ~axis_q;
            end
        end else begin
            grant_phi_s = bus.req_phi;
        end
        grant_dir_s   = grant_phi_s ? bus.dir_phi   : bus.dir_theta;
        grant_steps_s = grant_phi_s ? bus.steps_phi : bus.steps_theta;
`ifdef AXIS_SCHED_DEADSKIP_EN
        skip_dead_s = hist_valid_q && (hist_axis_q == grant_phi_s) &&
                      (hist_dir_q == grant_dir_s);
`else
        skip_dead_s = 1'b0;
`endif
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        axis_d      = axis_q;
        dir_d       = dir_q;
        ack_theta_d = 1'b0;
        ack_phi_d   = 1'b0;
`ifdef AXIS_SCHED_DEADSKIP_EN
        hist_valid_d = hist_valid_q;
        hist_axis_d  = hist_axis_q;
        hist_dir_d   = hist_dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    axis_d      = grant_phi_s;
                    dir_d       = grant_dir_s;
                    rem_d       = grant_steps_s;
                    ack_theta_d = ~grant_phi_s;
                    ack_phi_d   = grant_phi_s;
                    if (grant_steps_s == REM_ZERO) begin
                        // Zero-length move: one ack cycle, then the done cycle.
                        state_d = ST_DONE;
                        cnt_d   = CNT_ONE;
                    end else if (skip_dead_s) begin
                        state_d = ST_RUN_A;
                        cnt_d   = STEP_LOAD;
                    end else begin
                        state_d = ST_DEAD;
                        cnt_d   = DEAD_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_DEAD: begin
                if (bus.abort) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                    rem_d   = REM_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_RUN_A;
                    cnt_d   = STEP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN_A: begin
                if (bus.abort) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                    rem_d   = REM_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_RUN_B;
                    cnt_d   = STEP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RUN_B: begin
                if (bus.abort) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                    rem_d   = REM_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    // rem_q is never 0 here: zero-length moves bypass the run states.
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_RUN_A;
                        cnt_d   = STEP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                rem_d   = REM_ZERO;
            end
        endcase

`ifdef AXIS_SCHED_DEADSKIP_EN
        if ((state_q != ST_IDLE) && (state_q != ST_DONE) && bus.abort) begin
            hist_valid_d = 1'b0;
        end else if ((state_q == ST_RUN_B) && (cnt_q == CNT_ZERO) && (rem_q == REM_ONE)) begin
            hist_valid_d = 1'b1;
            hist_axis_d  = axis_q;
            hist_dir_d   = dir_q;
        end else begin
            hist_valid_d = hist_valid_q;
        end
`endif

        // Outputs follow the next state so they line up with it cycle for cycle.
        code_s      = phase_code(state_d);
        theta_pos_d = (!axis_d &&  dir_d) ? code_s : 2'b00;
        theta_neg_d = (!axis_d && !dir_d) ? code_s : 2'b00;
        phi_pos_d   = ( axis_d &&  dir_d) ? code_s : 2'b00;
        phi_neg_d   = ( axis_d && !dir_d) ? code_s : 2'b00;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE) && (cnt_d == CNT_ZERO);
    end

    // State, counters and output registers; reset forces all drive codes off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            rem_q       <= REM_ZERO;
            axis_q      <= 1'b1;
            dir_q       <= 1'b0;
            ack_theta_q <= 1'b0;
            ack_phi_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            theta_pos_q <= 2'b00;
            theta_neg_q <= 2'b00;
            phi_pos_q   <= 2'b00;
            phi_neg_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            axis_q      <= axis_d;
            dir_q       <= dir_d;
            ack_theta_q <= ack_theta_d;
            ack_phi_q   <= ack_phi_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            theta_pos_q <= theta_pos_d;
            theta_neg_q <= theta_neg_d;
            phi_pos_q   <= phi_pos_d;
            phi_neg_q   <= phi_neg_d;
        end
    end

`ifdef AXIS_SCHED_DEADSKIP_EN
    // Dead-time skip history; reset forgets it so the first move always waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_valid_q <= 1'b0;
            hist_axis_q  <= 1'b0;
            hist_dir_q   <= 1'b0;
        end else begin
            hist_valid_q <= hist_valid_d;
            hist_axis_q  <= hist_axis_d;
            hist_dir_q   <= hist_dir_d;
        end
    end
`endif

    assign bus.ack_theta       = ack_theta_q;
    assign bus.ack_phi         = ack_phi_q;
    assign bus.s_out_theta_pos = theta_pos_q;
    assign bus.s_out_theta_neg = theta_neg_q;
    assign bus.s_out_phi_pos   = phi_pos_q;
    assign bus.s_out_phi_neg   = phi_neg_q;
    assign bus.busy            = busy_q;
    assign bus.active_axis     = axis_q;
    assign bus.done            = done_q;

endmodule
